// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - N-input valid/ready mux with registered output stage, external-select or round-robin grant
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N),
  parameter int RR    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_src
);

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_src;
  logic [SEL_W-1:0]   r_ptr;

  logic               w_space;
  logic               w_found;
  logic               w_take;
  logic [SEL_W-1:0]   w_idx;
  logic [SEL_W-1:0]   w_cand;
  logic [WIDTH-1:0]   w_word;

  // Round-robin searches upward from the channel after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    if (RR != 0) begin
      for (int off = 1; off <= N; off++) begin
        w_cand = SEL_W'((int'(r_ptr) + off) % N);
        if (!w_found && in_valid[w_cand]) begin
          w_found = 1'b1;
          w_idx   = w_cand;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (sel == SEL_W'(k) && in_valid[k]) begin
          w_found = 1'b1;
          w_idx   = SEL_W'(k);
        end
      end
    end
  end

  assign w_space = !r_out_valid || out_ready;
  assign w_take  = w_found && w_space && !rst;

  always_comb begin
    in_ready = '0;
    if (w_take) in_ready[w_idx] = 1'b1;
  end

  always_comb begin
    w_word = '0;
    for (int k = 0; k < N; k++) begin
      if (w_idx == SEL_W'(k)) w_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= SEL_W'(N - 1);
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_src   <= w_idx;
      if (RR != 0) r_ptr <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb/tb_arb_mux_n.sv - bench for arb_mux_n: select-mode N=4, round-robin N=4, select-mode N=5
module tb_arb_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        out_ready;
  logic [4:0]  v[3];
  logic [31:0] w[3][5];
  logic [2:0]  s[3];

  logic [127:0] id0, id1;
  logic [159:0] id2;
  logic [3:0]   iv0, iv1, rdy0, rdy1;
  logic [4:0]   iv2, rdy2;
  logic [1:0]   is0, is1, os0, os1;
  logic [2:0]   is2, os2;
  logic [31:0]  od0, od1, od2;
  logic         ov0, ov1, ov2;

  assign id0 = {w[0][3], w[0][2], w[0][1], w[0][0]};
  assign id1 = {w[1][3], w[1][2], w[1][1], w[1][0]};
  assign id2 = {w[2][4], w[2][3], w[2][2], w[2][1], w[2][0]};
  assign iv0 = v[0][3:0];
  assign iv1 = v[1][3:0];
  assign iv2 = v[2];
  assign is0 = s[0][1:0];
  assign is1 = s[1][1:0];
  assign is2 = s[2];

  arb_mux_n #(.WIDTH(32), .N(4), .RR(0)) u_sel4 (
    .clk(clk), .rst(rst), .in_data(id0), .in_valid(iv0), .in_ready(rdy0), .sel(is0),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_src(os0));
  arb_mux_n #(.WIDTH(32), .N(4), .RR(1)) u_rr4 (
    .clk(clk), .rst(rst), .in_data(id1), .in_valid(iv1), .in_ready(rdy1), .sel(is1),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_src(os1));
  arb_mux_n #(.WIDTH(32), .N(5), .RR(0)) u_sel5 (
    .clk(clk), .rst(rst), .in_data(id2), .in_valid(iv2), .in_ready(rdy2), .sel(is2),
    .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .out_src(os2));

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the consumer should be looking at, and the last winner.
  logic        m_valid[3];
  logic [31:0] m_data[3];
  int          m_src[3];
  int          m_ptr[3];
  logic [4:0]  m_acc[3];

  function automatic logic [4:0] exp_ready(int d);
    int n, g, c;
    n = (d == 2) ? 5 : 4;
    g = -1;
    if (d == 1) begin
      for (int o = 1; o <= n; o++) begin
        c = (m_ptr[d] + o) % n;
        if (g < 0 && v[d][c[2:0]]) g = c;
      end
    end else if (int'(s[d]) < n && v[d][s[d]]) begin
      g = int'(s[d]);
    end
    if (rst || (m_valid[d] && !out_ready) || g < 0) return 5'd0;
    return 5'd1 << g;
  endfunction

  function automatic logic [4:0] obs_ready(int d);
    case (d)
      0:       return {1'b0, rdy0};
      1:       return {1'b0, rdy1};
      default: return rdy2;
    endcase
  endfunction

  function automatic logic [35:0] obs_out(int d);
    case (d)
      0:       return {ov0, 1'b0, os0, od0};
      1:       return {ov1, 1'b0, os1, od1};
      default: return {ov2, os2, od2};
    endcase
  endfunction

  function automatic logic [35:0] exp_out(int d);
    return {m_valid[d], 3'(m_src[d]), m_data[d]};
  endfunction

  task automatic tick();
    logic [4:0] r[3];
    for (int d = 0; d < 3; d++) r[d] = exp_ready(d);
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      m_acc[d] = r[d] & v[d];
      if (rst) begin
        m_valid[d] = 1'b0; m_data[d] = '0; m_src[d] = 0; m_ptr[d] = (d == 2) ? 4 : 3;
      end else if (m_acc[d] != 5'd0) begin
        for (int k = 0; k < 5; k++) begin
          if (m_acc[d][k]) begin
            m_data[d] = w[d][k]; m_src[d] = k;
            if (d == 1) m_ptr[d] = k;
          end
        end
        m_valid[d] = 1'b1;
      end else if (out_ready) begin
        m_valid[d] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 3; d++) begin
      v[d] = '0; s[d] = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      v[d] = (d == 2) ? 5'h1f : 5'h0f; s[d] = '0;
      for (int k = 0; k < 5; k++) w[d][k] = $urandom;
    end
    repeat (2) begin
      #1;
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if (obs_ready(d) !== 5'd0) begin n_err++; $display("FAIL rst_ready[%0d]: got %b expected 00000", d, obs_ready(d)); end
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if (obs_out(d) !== 36'd0) begin n_err++; $display("FAIL rst_out[%0d]: got %h expected 0", d, obs_out(d)); end
      end
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs_ready(1) !== 5'b00001) begin n_err++; $display("FAIL rst_first_grant: got %b expected 00001", obs_ready(1)); end
    tick();
    n_vec++;
    if (obs_out(1) !== {1'b1, 3'd0, w[1][0]}) begin n_err++; $display("FAIL rst_first_out: got %h expected %h", obs_out(1), {1'b1, 3'd0, w[1][0]}); end
  endtask

  task automatic test_sel();
    clear_inputs(); out_ready = 1'b1;
    tick(); tick();
    s[0] = 3'd2; v[0] = 5'b00110; w[0][2] = 32'hDEADBEEF; w[0][1] = $urandom;
    #1;
    n_vec++;
    if (obs_ready(0) !== 5'b00100) begin n_err++; $display("FAIL sel2_ready: got %b expected 00100", obs_ready(0)); end
    tick();
    n_vec++;
    if (obs_out(0) !== {1'b1, 3'd2, 32'hDEADBEEF}) begin n_err++; $display("FAIL sel2_out: got %h expected %h", obs_out(0), {1'b1, 3'd2, 32'hDEADBEEF}); end
    s[0] = 3'd3;
    #1;
    n_vec++;
    if (obs_ready(0) !== 5'd0) begin n_err++; $display("FAIL sel3_ready: got %b expected 00000", obs_ready(0)); end
    tick();
    n_vec++;
    if (obs_out(0) !== {1'b0, 3'd2, 32'hDEADBEEF}) begin n_err++; $display("FAIL sel3_idle: got %h expected %h", obs_out(0), {1'b0, 3'd2, 32'hDEADBEEF}); end
    s[2] = 3'd5; v[2] = 5'h1f;
    #1;
    n_vec++;
    if (obs_ready(2) !== 5'd0) begin n_err++; $display("FAIL sel5_ready: got %b expected 00000", obs_ready(2)); end
    tick();
    n_vec++;
    if (obs_out(2)[35] !== 1'b0) begin n_err++; $display("FAIL sel5_idle: got %b expected 0", obs_out(2)[35]); end
  endtask

  task automatic test_rr_rotation();
    clear_inputs(); rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    v[1] = 5'h0f;
    for (int k = 0; k < 4; k++) w[1][k] = 32'hA0A0_0000 + k;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (obs_out(1) !== {1'b1, 3'(i % 4), w[1][i % 4]}) begin n_err++; $display("FAIL rr_rotate[%0d]: got %h expected %h", i, obs_out(1), {1'b1, 3'(i % 4), w[1][i % 4]}); end
    end
  endtask

  task automatic test_stall();
    clear_inputs(); out_ready = 1'b1;
    tick();
    s[0] = 3'd1; v[0] = 5'b00010; w[0][1] = 32'h11;
    tick();
    w[0][1] = 32'h22; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (obs_ready(0) !== 5'd0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b expected 00000", i, obs_ready(0)); end
      tick();
      n_vec++;
      if (obs_out(0) !== {1'b1, 3'd1, 32'h11}) begin n_err++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs_out(0), {1'b1, 3'd1, 32'h11}); end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (obs_ready(0) !== 5'b00010) begin n_err++; $display("FAIL stall_release_ready: got %b expected 00010", obs_ready(0)); end
    tick();
    n_vec++;
    if (obs_out(0) !== {1'b1, 3'd1, 32'h22}) begin n_err++; $display("FAIL stall_refill: got %h expected %h", obs_out(0), {1'b1, 3'd1, 32'h22}); end
  endtask

  task automatic test_rr_sparse();
    clear_inputs(); rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) w[1][k] = $urandom;
    v[1] = 5'b00010;
    tick();
    v[1] = 5'b01010;
    #1;
    n_vec++;
    if (obs_ready(1) !== 5'b01000) begin n_err++; $display("FAIL sparse_ch3_ready: got %b expected 01000", obs_ready(1)); end
    tick();
    n_vec++;
    if (obs_out(1) !== {1'b1, 3'd3, w[1][3]}) begin n_err++; $display("FAIL sparse_ch3_out: got %h expected %h", obs_out(1), {1'b1, 3'd3, w[1][3]}); end
    n_vec++;
    if (obs_ready(1) !== 5'b00010) begin n_err++; $display("FAIL sparse_ch1_ready: got %b expected 00010", obs_ready(1)); end
    tick();
    out_ready = 1'b0;
    tick();
    v[1] = 5'b00010;
    tick();
    v[1] = 5'b01010; out_ready = 1'b1;
    #1;
    n_vec++;
    if (obs_ready(1) !== 5'b01000) begin n_err++; $display("FAIL sparse_ptr_kept: got %b expected 01000", obs_ready(1)); end
    tick();
  endtask

  task automatic test_mid_reset();
    clear_inputs(); out_ready = 1'b1;
    tick();
    w[1][0] = 32'h55; v[1] = 5'b00001;
    tick();
    v[1] = '0; out_ready = 1'b0;
    tick();
    n_vec++;
    if (obs_out(1) !== {1'b1, 3'd0, 32'h55}) begin n_err++; $display("FAIL midrst_held: got %h expected %h", obs_out(1), {1'b1, 3'd0, 32'h55}); end
    rst = 1'b1;
    tick();
    n_vec++;
    if (obs_out(1) !== 36'd0) begin n_err++; $display("FAIL midrst_cleared: got %h expected 0", obs_out(1)); end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++;
    if (obs_out(1)[35] !== 1'b0) begin n_err++; $display("FAIL midrst_not_delivered: got %b expected 0", obs_out(1)[35]); end
    v[1] = 5'h0f; w[1][0] = 32'h66;
    #1;
    n_vec++;
    if (obs_ready(1) !== 5'b00001) begin n_err++; $display("FAIL midrst_restart: got %b expected 00001", obs_ready(1)); end
    tick();
  endtask

  task automatic test_random();
    clear_inputs(); out_ready = 1'b1;
    tick(); tick();
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 3; d++) begin
        for (int c = 0; c < ((d == 2) ? 5 : 4); c++) begin
          if (!(v[d][c] && !m_acc[d][c])) begin
            v[d][c] = ($urandom % 10) < 6;
            w[d][c] = $urandom;
          end
        end
      end
      s[0] = 3'($urandom % 4);
      s[2] = 3'($urandom % 8);
      out_ready = ($urandom % 10) < 7;
      #1;
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if (obs_ready(d) !== exp_ready(d)) begin n_err++; $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", d, i, obs_ready(d), exp_ready(d)); end
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if (obs_out(d) !== exp_out(d)) begin n_err++; $display("FAIL rand_out[%0d] cyc %0d: got %h expected %h", d, i, obs_out(d), exp_out(d)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_sel();
    test_rr_rotation();
    test_stall();
    test_rr_sparse();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-input, WIDTH-bit multiplexer with per-channel valid/ready handshakes, a registered single-entry output stage, and two selection modes: externally selected, or round-robin arbitration. It generalises the datapath select muxes to any width and channel count and adds flow control. It sits between multiple producers, such as load/store sources or write-back candidates, and one consumer that may stall.

## Interface
- WIDTH, 32, bit width of each data channel (≥1)
- N, 4, number of input channels (2..16)
- SEL_W, $clog2(N), width of sel and out_src
- RR, 0, 0 = external-select mode, 1 = round-robin arbitration mode

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  in  N  channel k offers a word
- in_ready  out  N  channel k's word is accepted this cycle
- sel  in  SEL_W  channel choice, used only when RR=0
- out_data  out  WIDTH  registered output word
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer takes out_data this cycle
- out_src  out  SEL_W  index of the channel that supplied out_data

## Operation
- Transfer in: channel k transfers when in_valid[k] && in_ready[k] at a rising edge.
- Transfer out: the consumer takes the word when out_valid && out_ready at a rising edge.
- space = !out_valid || out_ready. This is a pass-through ready: the stage can refill in the same cycle it drains.
- Grant is combinational and one-hot or zero:
  - RR=0: grant = sel when sel < N and in_valid[sel]. Otherwise there is no grant. sel ≥ N grants nothing, matching the out-of-range default-0 behaviour of the select muxes.
  - RR=1: search from channel (ptr+1) mod N upward, wrapping. The first channel with in_valid set wins.
- in_ready[k] = space && grant==k. All other bits are 0. in_ready never depends on in_valid of the same channel in RR=0, except through the sel check.
- On a transfer in: out_data ← word of channel k, out_src ← k, out_valid ← 1. If RR=1, ptr ← k.
- On a transfer out with no transfer in: out_valid ← 0. out_data and out_src hold their last value.
- On simultaneous out and in transfers: the new word replaces the old one, and out_valid stays 1. No bubble, no loss.
- ptr changes only on an accepted transfer. Stalled requests keep their priority position.
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=N-1 (channel 0 has first priority), in_ready=0 during the reset cycle.
- If rst is asserted mid-operation, a held word is discarded, not delivered. Any handshake that coincides with the reset edge is ignored.
- Input words must be held stable by producers while in_valid=1 and not yet accepted. The block never reorders or duplicates words.

## Timing
- Latency: 1 cycle. A word accepted at edge t is visible on out_data/out_valid after edge t.
- Throughput: 1 word per cycle while out_ready=1 and any grantable channel is valid.
- Backpressure: when out_valid=1 and out_ready=0, every in_ready is 0 within the same cycle, combinationally.
- Combinational paths: out_ready→in_ready, in_valid→in_ready, and sel→in_ready. There is no combinational path from an input to out_data, out_valid or out_src.
- Fairness (RR=1): while all N channels stay valid and the output drains every cycle, grants rotate 0,1,…,N-1,0. Any continuously valid channel is served within N accepted transfers.

## Test plan
- Reset with N=4, WIDTH=32: assert rst for 2 cycles while all in_valid=1 → out_valid=0, out_data=0, out_src=0, and in_ready=0 during reset. After release, the first grant goes to channel 0.
- RR=0, sel=2, in_valid=4'b0110, in_data ch2=0xDEADBEEF, out_ready=1 → in_ready=4'b0100, and the next cycle shows out_data=0xDEADBEEF, out_src=2. With sel=3 the output is idle, and with sel=5 (SEL_W widened to 3, N=5 build) in_ready=0.
- RR=1, all 4 channels valid with distinct data, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3, with one word per cycle and no bubbles.
- Stall: out_valid=1 holding 0x11, out_ready=0 for 3 cycles → in_ready=0 throughout and out_data stays 0x11. Release out_ready → 0x11 is consumed and a new word loads on the same edge, so out_valid stays 1.
- RR=1, only ch1 and ch3 valid, ptr=1 → ch3 is granted, then ch1. Dropping ch3 while stalled leaves ptr unchanged.
- Mid-operation reset: out_valid=1 with word 0x55 and out_ready=0, assert rst for 1 cycle → out_valid=0 and 0x55 is never delivered. Arbitration restarts at channel 0.
